uart_word_rx: RTL and testbench
===============================

# uart_word_rx

Parametrised receive-side word assembler that sits directly behind `uart_rx` (and its `mod_m_counter` baud tick). It packs `NBYTES` consecutive DBIT-wide bytes into one word, with:
- selectable byte order,
- an inter-byte timeout that discards partial words,
- a one-entry valid/ready output register with overrun detection.

It replaces ad-hoc two-byte collection logic and feeds host-link and debug consumers of the BIP datapath (e.g. 16-bit accumulator readback).

## Interface
Parameters:
- `DBIT`, 8, bits per received byte (matches `uart_rx`)
- `NBYTES`, 2, bytes per word; legal range 1..8
- `BIG_ENDIAN`, 0, byte placement: 0 puts the first byte in `[DBIT-1:0]`; 1 puts the first byte in the MS byte
- `TIMEOUT_TICKS`, 160, `i_s_tick` pulses allowed between bytes of one word (160 = 10 bit times at 16x oversampling); 0 disables the timeout
- `NBITS_W`, DBIT*NBYTES, output word width (derived; do not override)

Ports:
- `i_clk`  in  1  system clock
- `i_reset`  in  1  synchronous, active-high reset
- `i_rx_done`  in  1  one-cycle byte strobe from `uart_rx`
- `i_rx_data`  in  DBIT  received byte; valid only when `i_rx_done`=1
- `i_s_tick`  in  1  oversampling tick from `mod_m_counter`
- `i_ready`  in  1  consumer accepts `o_data` this cycle
- `o_data`  out  NBITS_W  assembled word; stable while `o_valid`=1
- `o_valid`  out  1  word available
- `o_byte_cnt`  out  clog2(NBYTES+1)  bytes held in the current partial word
- `o_timeout`  out  1  one-cycle pulse: a partial word was discarded
- `o_overrun`  out  1  one-cycle pulse: a completed word was dropped

## Operation
- States:
  - IDLE: no partial word.
  - COLLECT: 1..NBYTES-1 bytes held.
- Byte capture, on any state with `i_rx_done`=1:
  - The byte is written into slot `byte_cnt` of the shift/assembly register. The slot is mirrored when BIG_ENDIAN=1.
  - `byte_cnt` increments.
  - The timeout counter clears.
- Word completion, when the captured byte is byte NBYTES:
  - The assembled word transfers to the output register, `byte_cnt` returns to 0, and the state returns to IDLE.
  - NBYTES=1 never enters COLLECT.
- Output register:
  - `o_valid` sets on transfer.
  - `o_valid` clears on the cycle `o_valid && i_ready`.
- Overrun: word completes while `o_valid`=1 and `i_ready`=0.
  - The new word is dropped and the held word is kept.
  - `o_overrun` pulses.
  - Completion in the same cycle as `o_valid && i_ready` is NOT an overrun: the new word loads and `o_valid` stays 1.
- Timeout:
  - In COLLECT, each `i_s_tick` without `i_rx_done` increments the counter.
  - When the counter reaches TIMEOUT_TICKS, the partial word is discarded, `byte_cnt` goes to 0, the state goes to IDLE and `o_timeout` pulses.
  - If `i_rx_done` and the terminal tick occur in the same cycle, `i_rx_done` wins and no timeout occurs.
  - The counter is inactive in IDLE.
  - Counter width is clog2(TIMEOUT_TICKS+1).
- Unused assembly bits are don't-care internally. `o_data` only changes on transfer.

## Timing
- Reset values:
  - `o_data`=0, `o_valid`=0, `o_byte_cnt`=0, `o_timeout`=0, `o_overrun`=0.
  - State is IDLE and the timeout counter is 0.
- Reset mid-word discards the partial word and any held output word. The first `i_rx_done` after reset deasserts is byte 0.
- Latency: `o_valid`=1 on the cycle after the clock edge sampling the final `i_rx_done` (1 cycle registered). `o_data` is valid the same cycle.
- `o_byte_cnt` updates one cycle after each sampled `i_rx_done`.
- `o_timeout` and `o_overrun` are registered and high for exactly one cycle.
- `i_ready` has no effect while `o_valid`=0. Consumers may hold `i_ready` high permanently.
- Throughput: one byte per cycle max. `uart_rx` delivers far slower, so there is no back-pressure to the UART.

## Structure
- Shared package/include `uart_word_pkg`:
  - state encodings IDLE/COLLECT
  - a `clog2` constant function
  - the default TIMEOUT_TICKS value (16*10)
- One sub-module: `tick_timeout_counter`, which counts enabled ticks, clears synchronously, and pulses on reaching a parameter limit (limit 0 means never). It is reusable by the TX side.
- Remaining logic (assembly register, byte index, output stage) stays flat in `uart_word_rx`.

## Test plan
- Defaults, bytes 0x34 then 0x12, `i_ready`=1 → one-cycle `o_valid` with `o_data`=0x1234; `o_byte_cnt` goes 0→1→0.
- BIG_ENDIAN=1, NBYTES=4, bytes 0xDE,0xAD,0xBE,0xEF → `o_data`=0xDEADBEEF.
- Byte 0xAA, then 160 ticks with no byte → `o_timeout` pulse, `o_byte_cnt`=0, no `o_valid`. Then bytes 0x01,0x02 → `o_data`=0x0201. Also drive the final `i_rx_done` coincident with tick 160 → no timeout.
- `i_ready`=0, words 0x1111 then 0x2222 → `o_overrun` pulse; `o_data` stays 0x1111 until accepted. Repeat with `i_ready`=1 on the completion cycle → 0x2222 loads, no overrun.
- `i_reset` after one byte of 0x55 → all outputs 0. Subsequent bytes 0x0F,0xF0 → `o_data`=0xF00F.
- NBYTES=1, TIMEOUT_TICKS=0, byte 0x7E → `o_valid` next cycle with 0x7E. Idle ticks never raise `o_timeout`.

Source files
------------

// File: rtl/uart_word_pkg.sv
// Shared definitions for the UART word assembler and its tick timeout helper.
package uart_word_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } rx_state_t;

    // Ten bit times at 16x oversampling.
    localparam int DEFAULT_TIMEOUT_TICKS = 16 * 10;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/tick_timeout_counter.sv
// Counts enabled ticks and pulses (combinationally) on the tick that reaches LIMIT.
// LIMIT = 0 disables expiry entirely; clear takes priority over counting.
module tick_timeout_counter
    import uart_word_pkg::*;
#(
    parameter int LIMIT = DEFAULT_TIMEOUT_TICKS
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (clog2(LIMIT + 1) > 0) ? clog2(LIMIT + 1) : 1;

    logic [CW-1:0] count;

    always_comb begin
        expired = (LIMIT != 0) && enable && !clear && (count == CW'(LIMIT - 1));
    end

    always_ff @(posedge clk) begin
        if (reset || clear || expired) begin
            count <= '0;
        end else if (enable && (LIMIT != 0)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_word_rx.sv
// Packs NBYTES received UART bytes into one word with selectable byte order,
// an inter-byte timeout and a single-entry valid/ready output register.
module uart_word_rx
    import uart_word_pkg::*;
#(
    parameter int DBIT          = 8,
    parameter int NBYTES        = 2,
    parameter int BIG_ENDIAN    = 0,
    parameter int TIMEOUT_TICKS = DEFAULT_TIMEOUT_TICKS,
    parameter int NBITS_W       = DBIT * NBYTES
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_rx_done,
    input  logic [DBIT-1:0]             i_rx_data,
    input  logic                        i_s_tick,
    input  logic                        i_ready,
    output logic [NBITS_W-1:0]          o_data,
    output logic                        o_valid,
    output logic [clog2(NBYTES+1)-1:0]  o_byte_cnt,
    output logic                        o_timeout,
    output logic                        o_overrun
);

    localparam int BCW = clog2(NBYTES + 1);

    rx_state_t          state;
    rx_state_t          state_next;
    logic [BCW-1:0]     byte_cnt;
    logic [BCW-1:0]     byte_cnt_next;
    logic [BCW-1:0]     slot;
    logic [NBITS_W-1:0] assembly;
    logic [NBITS_W-1:0] word_next;
    logic               last_byte;
    logic               word_done;
    logic               tick_enable;
    logic               tick_clear;
    logic               timeout_hit;

    // word_next is the assembly register with the incoming byte already merged,
    // so a completing byte can go straight to the output register.
    always_comb begin
        last_byte = (byte_cnt == BCW'(NBYTES - 1));
        word_done = i_rx_done && last_byte;
        slot      = (BIG_ENDIAN != 0) ? (BCW'(NBYTES - 1) - byte_cnt) : byte_cnt;
        word_next = assembly;
        for (int i = 0; i < NBYTES; i++) begin
            if (slot == BCW'(i)) begin
                word_next[i*DBIT +: DBIT] = i_rx_data;
            end
        end
        tick_enable = (state == COLLECT) && i_s_tick && !i_rx_done;
        tick_clear  = i_rx_done || (state == IDLE);
    end

    tick_timeout_counter #(
        .LIMIT(TIMEOUT_TICKS)
    ) u_timeout (
        .clk    (i_clk),
        .reset  (i_reset),
        .clear  (tick_clear),
        .enable (tick_enable),
        .expired(timeout_hit)
    );

    always_comb begin
        state_next    = state;
        byte_cnt_next = byte_cnt;
        if (i_rx_done) begin
            if (last_byte) begin
                state_next    = IDLE;
                byte_cnt_next = '0;
            end else begin
                state_next    = COLLECT;
                byte_cnt_next = byte_cnt + 1'b1;
            end
        end else if (timeout_hit) begin
            state_next    = IDLE;
            byte_cnt_next = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state    <= IDLE;
            byte_cnt <= '0;
            assembly <= '0;
        end else begin
            state    <= state_next;
            byte_cnt <= byte_cnt_next;
            if (i_rx_done) begin
                assembly <= word_next;
            end
        end
    end

    // A held word that is being accepted this cycle frees the register for a new one.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_data    <= '0;
            o_valid   <= 1'b0;
            o_timeout <= 1'b0;
            o_overrun <= 1'b0;
        end else begin
            o_timeout <= timeout_hit;
            o_overrun <= word_done && o_valid && !i_ready;
            if (word_done && !(o_valid && !i_ready)) begin
                o_data  <= word_next;
                o_valid <= 1'b1;
            end else if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end
        end
    end

    assign o_byte_cnt = byte_cnt;

endmodule

// File: tb/tb_uart_word_rx.sv
// Three uart_word_rx configurations share one byte stream; a queue-based reference
// model predicts every word and pulse, and a negedge monitor compares.
module tb_uart_word_rx;

    localparam int NDUT = 3;
    localparam int NB [NDUT] = '{2, 4, 1};
    localparam int BE [NDUT] = '{0, 1, 0};
    localparam int TO [NDUT] = '{160, 20, 0};

    logic       clk;
    logic       reset;
    logic       rx_done;
    logic [7:0] rx_data;
    logic       s_tick;
    logic       ready;

    logic [15:0] d0_data;
    logic        d0_valid;
    logic [1:0]  d0_cnt;
    logic        d0_to;
    logic        d0_ov;
    logic [31:0] d1_data;
    logic        d1_valid;
    logic [2:0]  d1_cnt;
    logic        d1_to;
    logic        d1_ov;
    logic [7:0]  d2_data;
    logic        d2_valid;
    logic [0:0]  d2_cnt;
    logic        d2_to;
    logic        d2_ov;

    logic [63:0] out_data  [NDUT];
    logic [63:0] out_cnt   [NDUT];
    logic        out_valid [NDUT];
    logic        out_to    [NDUT];
    logic        out_ov    [NDUT];

    uart_word_rx u_dut0 (
        .i_clk(clk), .i_reset(reset), .i_rx_done(rx_done), .i_rx_data(rx_data),
        .i_s_tick(s_tick), .i_ready(ready), .o_data(d0_data), .o_valid(d0_valid),
        .o_byte_cnt(d0_cnt), .o_timeout(d0_to), .o_overrun(d0_ov)
    );

    uart_word_rx #(.NBYTES(4), .BIG_ENDIAN(1), .TIMEOUT_TICKS(20)) u_dut1 (
        .i_clk(clk), .i_reset(reset), .i_rx_done(rx_done), .i_rx_data(rx_data),
        .i_s_tick(s_tick), .i_ready(ready), .o_data(d1_data), .o_valid(d1_valid),
        .o_byte_cnt(d1_cnt), .o_timeout(d1_to), .o_overrun(d1_ov)
    );

    uart_word_rx #(.NBYTES(1), .TIMEOUT_TICKS(0)) u_dut2 (
        .i_clk(clk), .i_reset(reset), .i_rx_done(rx_done), .i_rx_data(rx_data),
        .i_s_tick(s_tick), .i_ready(ready), .o_data(d2_data), .o_valid(d2_valid),
        .o_byte_cnt(d2_cnt), .o_timeout(d2_to), .o_overrun(d2_ov)
    );

    assign out_data[0]  = {48'd0, d0_data};
    assign out_data[1]  = {32'd0, d1_data};
    assign out_data[2]  = {56'd0, d2_data};
    assign out_cnt[0]   = {62'd0, d0_cnt};
    assign out_cnt[1]   = {61'd0, d1_cnt};
    assign out_cnt[2]   = {63'd0, d2_cnt};
    assign out_valid[0] = d0_valid;
    assign out_valid[1] = d1_valid;
    assign out_valid[2] = d2_valid;
    assign out_to[0]    = d0_to;
    assign out_to[1]    = d1_to;
    assign out_to[2]    = d2_to;
    assign out_ov[0]    = d0_ov;
    assign out_ov[1]    = d1_ov;
    assign out_ov[2]    = d2_ov;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          dut;
        logic [63:0] word;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  part_bytes [NDUT][8];
    int          part_len   [NDUT];
    int          idle_ticks [NDUT];
    logic        held       [NDUT];
    logic [63:0] held_word  [NDUT];
    logic        exp_to     [NDUT];
    logic        exp_ov     [NDUT];

    int   n_checks;
    int   n_errors;
    logic mon_en;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: bytes collect in a list; a full list becomes a word,
    // placed little- or big-endian; idle ticks while partial count toward timeout.
    always @(posedge clk) begin
        for (int d = 0; d < NDUT; d++) begin
            logic [63:0] w;
            logic        accept;
            int          pos;
            exp_to[d] = 1'b0;
            exp_ov[d] = 1'b0;
            if (reset) begin
                part_len[d]   = 0;
                idle_ticks[d] = 0;
                held[d]       = 1'b0;
                held_word[d]  = '0;
                for (int k = exp_q.size() - 1; k >= 0; k--) begin
                    if (exp_q[k].dut == d) exp_q.delete(k);
                end
            end else begin
                accept = held[d] && ready;
                if (rx_done) begin
                    part_bytes[d][part_len[d]] = rx_data;
                    part_len[d]   = part_len[d] + 1;
                    idle_ticks[d] = 0;
                    if (part_len[d] == NB[d]) begin
                        w = '0;
                        for (int k = 0; k < NB[d]; k++) begin
                            pos = (BE[d] != 0) ? (NB[d] - 1 - k) : k;
                            w   = w | (64'(part_bytes[d][k]) << (8 * pos));
                        end
                        part_len[d] = 0;
                        if (held[d] && !ready) begin
                            exp_ov[d] = 1'b1;
                        end else begin
                            exp_q.push_back('{dut: d, word: w});
                            held[d]      = 1'b1;
                            held_word[d] = w;
                        end
                    end else if (accept) begin
                        held[d] = 1'b0;
                    end
                end else begin
                    if (accept) held[d] = 1'b0;
                    if (part_len[d] > 0 && s_tick && TO[d] != 0) begin
                        idle_ticks[d] = idle_ticks[d] + 1;
                        if (idle_ticks[d] == TO[d]) begin
                            part_len[d]   = 0;
                            idle_ticks[d] = 0;
                            exp_to[d]     = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Monitor: compares every output each cycle and pops the scoreboard on acceptance.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int d = 0; d < NDUT; d++) begin
                int idx;
                checkOutput($sformatf("dut%0d o_byte_cnt", d), out_cnt[d], 64'(part_len[d]));
                checkOutput($sformatf("dut%0d o_timeout", d), 64'(out_to[d]), 64'(exp_to[d]));
                checkOutput($sformatf("dut%0d o_overrun", d), 64'(out_ov[d]), 64'(exp_ov[d]));
                checkOutput($sformatf("dut%0d o_valid", d), 64'(out_valid[d]), 64'(held[d]));
                checkOutput($sformatf("dut%0d o_data", d), out_data[d], held_word[d]);
                if (out_valid[d] && ready) begin
                    idx = -1;
                    for (int k = 0; k < exp_q.size(); k++) begin
                        if (idx < 0 && exp_q[k].dut == d) idx = k;
                    end
                    if (idx < 0) begin
                        checkOutput($sformatf("dut%0d unexpected word", d), out_data[d], 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        checkOutput($sformatf("dut%0d accepted word", d), out_data[d], exp_q[idx].word);
                        exp_q.delete(idx);
                    end
                end
            end
        end
    end

    task automatic applyStimulus(input logic rst, input logic rx, input logic [7:0] data,
                                 input logic tick, input logic rdy);
        @(posedge clk);
        #1;
        reset   = rst;
        rx_done = rx;
        rx_data = data;
        s_tick  = tick;
        ready   = rdy;
    endtask

    task automatic sendByte(input logic [7:0] b, input logic rdy);
        applyStimulus(1'b0, 1'b1, b, 1'b0, rdy);
    endtask

    task automatic idleCycles(input int n, input logic tick, input logic rdy);
        repeat (n) applyStimulus(1'b0, 1'b0, 8'h00, tick, rdy);
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    initial begin
        int   left;
        logic fast;
        n_checks = 0;
        n_errors = 0;
        mon_en   = 1'b0;
        reset    = 1'b1;
        rx_done  = 1'b0;
        rx_data  = 8'h00;
        s_tick   = 1'b0;
        ready    = 1'b1;
        doReset();
        mon_en = 1'b1;

        // Little-endian pair with a permanently ready consumer
        sendByte(8'h34, 1'b1);
        idleCycles(1, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("le byte_cnt after first byte", out_cnt[0], 64'd1);
        sendByte(8'h12, 1'b1);
        idleCycles(1, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("le word", out_data[0], 64'h1234);
        checkOutput("le valid", 64'(out_valid[0]), 64'd1);
        checkOutput("le byte_cnt after word", out_cnt[0], 64'd0);
        idleCycles(1, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("le valid one cycle", 64'(out_valid[0]), 64'd0);

        // Big-endian four-byte word
        doReset();
        sendByte(8'hDE, 1'b1);
        sendByte(8'hAD, 1'b1);
        sendByte(8'hBE, 1'b1);
        sendByte(8'hEF, 1'b1);
        idleCycles(1, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("be word", out_data[1], 64'hDEAD_BEEF);

        // Timeout after 160 idle ticks, then a clean word
        doReset();
        sendByte(8'hAA, 1'b1);
        idleCycles(160, 1'b1, 1'b1);
        idleCycles(1, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("timeout pulse", 64'(out_to[0]), 64'd1);
        checkOutput("timeout byte_cnt", out_cnt[0], 64'd0);
        checkOutput("timeout no valid", 64'(out_valid[0]), 64'd0);
        sendByte(8'h01, 1'b1);
        sendByte(8'h02, 1'b1);
        idleCycles(1, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("post-timeout word", out_data[0], 64'h0201);

        // Final byte coincides with the terminal tick: byte wins
        doReset();
        sendByte(8'h11, 1'b1);
        idleCycles(159, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 8'h22, 1'b1, 1'b1);
        idleCycles(1, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("coincident no timeout", 64'(out_to[0]), 64'd0);
        checkOutput("coincident word", out_data[0], 64'h2211);

        // Overrun with a stalled consumer
        doReset();
        sendByte(8'h11, 1'b0);
        sendByte(8'h11, 1'b0);
        sendByte(8'h22, 1'b0);
        sendByte(8'h22, 1'b0);
        idleCycles(1, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("overrun pulse", 64'(out_ov[0]), 64'd1);
        checkOutput("overrun keeps word", out_data[0], 64'h1111);
        idleCycles(1, 1'b0, 1'b1);
        idleCycles(1, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("overrun drained", 64'(out_valid[0]), 64'd0);

        // Completion on the accept cycle loads the new word
        sendByte(8'h11, 1'b0);
        sendByte(8'h11, 1'b0);
        sendByte(8'h22, 1'b0);
        sendByte(8'h22, 1'b1);
        idleCycles(1, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("accept+load word", out_data[0], 64'h2222);
        checkOutput("accept+load no overrun", 64'(out_ov[0]), 64'd0);
        checkOutput("accept+load valid", 64'(out_valid[0]), 64'd1);

        // Reset mid-word
        idleCycles(2, 1'b0, 1'b1);
        sendByte(8'h55, 1'b1);
        doReset();
        @(negedge clk);
        checkOutput("reset data", out_data[0], 64'h0);
        checkOutput("reset byte_cnt", out_cnt[0], 64'h0);
        checkOutput("reset valid", 64'(out_valid[0]), 64'h0);
        sendByte(8'h0F, 1'b1);
        sendByte(8'hF0, 1'b1);
        idleCycles(1, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("post-reset word", out_data[0], 64'hF00F);

        // Single-byte words, timeout disabled
        doReset();
        sendByte(8'h7E, 1'b1);
        idleCycles(1, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("nb1 word", out_data[2], 64'h7E);
        checkOutput("nb1 valid", 64'(out_valid[2]), 64'd1);
        idleCycles(300, 1'b1, 1'b1);

        // Randomized traffic: alternating fast and slow segments
        for (int seg = 0; seg < 60; seg++) begin
            fast = ($urandom_range(0, 1) == 1);
            for (int c = 0; c < 40; c++) begin
                applyStimulus($urandom_range(0, 999) == 0,
                              fast ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 47) == 0),
                              8'($urandom_range(0, 255)),
                              $urandom_range(0, 1) == 1,
                              $urandom_range(0, 3) != 0);
            end
        end

        idleCycles(5, 1'b0, 1'b1);
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            left = 0;
            for (int k = 0; k < exp_q.size(); k++) begin
                if (exp_q[k].dut == d) left++;
            end
            checkOutput($sformatf("dut%0d undelivered words", d), 64'(left), 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
